pipelined_alu: RTL
==================

Name: pipelined_alu

Overview:
- Parametrised, registered successor to the datapath's combinational 16-bit main ALU, placed in the EX stage of the 5-stage pipeline.
- Adds valid/ready handshakes on input and output, correct signed overflow detection, and a tag passthrough for the destination register.
- Adds an iterative signed multiply (MUL) that stalls the upstream stage while it runs.
- Keeps the 3-bit opcode space of the existing ALU.

Parameters:
- WIDTH, 16, operand width in bits (>=4).
- TAG_W, 4, width of the sideband tag carried from input to output unchanged.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous kill of any in-flight MUL and any held output.
- in_valid  in  1  operation offered.
- in_ready  out  1  block accepts the offer this cycle.
- op1  in  WIDTH  signed operand 1.
- op2  in  WIDTH  signed operand 2.
- alu_ctrl  in  3  opcode.
- in_tag  in  TAG_W  sideband tag.
- out_valid  out  1  result held in the output register.
- out_ready  in  1  consumer takes the result.
- result  out  2*WIDTH  signed result.
- overflow  out  1  signed overflow flag for the result.
- out_tag  out  TAG_W  tag of the result.

Behaviour:
- Reset (async): state=IDLE; out_valid=0; result=0; overflow=0; out_tag=0; iteration counter=0.
- Opcodes:
  - 000 ADD: low half = op1+op2, wrapped to WIDTH bits. overflow=1 when the operands have the same sign and the sum's sign differs.
  - 001 SUB: low half = op1-op2, wrapped. overflow=1 when the operand signs differ and the result's sign differs from op1.
  - 010 MOVE: op2.
  - 011 SWAP: result={op1,op2}, so the upper half is op1 and the lower half is op2.
  - 100 AND: op1&op2.
  - 101 OR, 111 OR: op1|op2.
  - 110 MUL: full 2*WIDTH signed product. overflow=1 when the product is not representable in WIDTH signed bits.
- Width rule: for all ops except SWAP and MUL, the upper WIDTH bits of result are the sign-extension of the lower half. overflow=0 for every op except ADD, SUB and MUL.
- Handshake:
  - in_ready = (state==IDLE) && (!out_valid || out_ready) && !flush.
  - Accept = in_valid && in_ready.
  - The output register holds result, overflow and out_tag stable while out_valid && !out_ready.
- States:
  - IDLE: on accepting a non-MUL op, the output register loads at the same edge; out_valid=1 next cycle (latency 1). Throughput is 1 per cycle while out_ready=1.
  - IDLE -> MUL_RUN on accepting MUL. Latched: |op1| and |op2| as WIDTH-bit unsigned values (|-2^(WIDTH-1)| fits), sign = op1[msb]^op2[msb], and the tag. Counter=WIDTH.
  - MUL_RUN: one shift-add iteration per cycle; counter decrements each cycle.
  - MUL_RUN -> IDLE on the edge where counter reaches 0. At that edge the product is negated if sign=1, then loaded into the output register, and out_valid=1. Total latency is WIDTH cycles; in_ready=0 throughout.
  - The output register is empty at MUL entry by construction, because acceptance required !out_valid || out_ready.
- Output drain: out_valid clears on the edge where out_valid && out_ready, unless a new result loads at the same edge; in that case out_valid stays 1 with the new data.
- flush: at the next edge, out_valid=0 and state=IDLE; any MUL is discarded and no input is accepted that cycle. flush overrides everything except rst.
- Reset mid-MUL: immediate abort to the reset values; no partial result is ever presented.
- Opcode and operands are sampled only at acceptance. Input changes during MUL_RUN have no effect.

Optional Feature:
- Macro: PIPELINED_ALU_SATURATE_EN.
- Defined: on ADD/SUB overflow, the low half clamps to 2^(WIDTH-1)-1 (positive overflow) or -2^(WIDTH-1) (negative overflow). The upper half is sign-extended and overflow is still set to 1. MUL is unaffected.
- Undefined: the low half wraps as above.

Decomposition:
- Package alu_pkg holds:
  - opcode localparams: OP_ADD, OP_SUB, OP_MOVE, OP_SWAP, OP_AND, OP_OR, OP_MUL.
  - state encodings: ST_IDLE, ST_MUL_RUN.
- One sub-module: seq_multiplier.
  - Inputs: start, magnitudes, sign.
  - Outputs: done, 2*WIDTH product.
  - Owns the counter, the shift-add datapath and the sign fix-up.
  - Shares clk, rst and flush with the parent.
- Opcode decode, the overflow logic and the output register stay in the parent.

Test Plan:
- WIDTH=16, ADD 0x7FFF+0x0001, out_ready=1 -> one cycle later result=0xFFFF8000, overflow=1. With PIPELINED_ALU_SATURATE_EN: result=0x00007FFF, overflow=1.
- SUB 0x8000-0x0001 -> result low=0x7FFF, overflow=1. Then SWAP op1=0x1234, op2=0xABCD -> result=0x1234ABCD, overflow=0.
- MUL -3 x 7, tag=5 -> in_ready=0 for 16 cycles; then result=0xFFFFFFEB (-21), overflow=0, out_tag=5. MUL 0x8000 x 0x8000 -> result=0x40000000, overflow=1.
- Back-to-back ADDs with out_ready held low for 3 cycles -> first result held stable, in_ready=0, no loss. On release, one result per cycle in order.
- flush asserted at cycle 8 of a MUL -> out_valid never rises for it, and in_ready=1 the cycle after flush deasserts. rst pulse mid-MUL -> all outputs 0 immediately.
- Output drain and new accept on the same edge (out_ready=1, in_valid=1) -> out_valid stays 1 and the result changes to the new value without a bubble.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: opcodes and FSM state encodings shared by pipelined_alu and its bench
package alu_pkg;
  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_MOVE = 3'b010;
  localparam logic [2:0] OP_SWAP = 3'b011;
  localparam logic [2:0] OP_AND  = 3'b100;
  localparam logic [2:0] OP_OR   = 3'b101;
  localparam logic [2:0] OP_MUL  = 3'b110;
  typedef enum logic {ST_IDLE = 1'b0, ST_MUL_RUN = 1'b1} state_t;
endpackage

// File: rtl/pipelined_alu_if.sv
// pipelined_alu_if: operand/result valid-ready bus between the EX stage and the ALU
interface pipelined_alu_if #(parameter int WIDTH = 16, parameter int TAG_W = 4);
  logic in_valid, in_ready, out_valid, out_ready, overflow;
  logic [WIDTH-1:0] op1, op2;
  logic [2:0] alu_ctrl;
  logic [TAG_W-1:0] in_tag, out_tag;
  logic [2*WIDTH-1:0] result;
  modport master(output in_valid, op1, op2, alu_ctrl, in_tag, out_ready,
                 input in_ready, out_valid, result, overflow, out_tag);
  modport slave(input in_valid, op1, op2, alu_ctrl, in_tag, out_ready,
                output in_ready, out_valid, result, overflow, out_tag);
endinterface

// File: rtl/pipelined_alu_seq_multiplier.sv
// seq_multiplier: unsigned shift-add multiplier, one bit per cycle, sign applied on the final sum
module seq_multiplier #(parameter int WIDTH = 16) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               start,
  input  logic [WIDTH-1:0]   mag_a,
  input  logic [WIDTH-1:0]   mag_b,
  input  logic               sign,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);
  localparam int CW = $clog2(WIDTH + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d, mcand_q, mcand_d, acc_nx;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic sign_q, sign_d, busy;
  // product is combinational off the last iteration so the parent loads it on the final edge
  always_comb begin
    busy = cnt_q != '0;
    acc_nx = acc_q + (mplier_q[0] ? mcand_q : '0);
    done = cnt_q == CW'(1);
    product = sign_q ? -acc_nx : acc_nx;
    cnt_d = flush ? '0 : start ? CW'(WIDTH) : busy ? cnt_q - CW'(1) : cnt_q;
    acc_d = start ? '0 : busy ? acc_nx : acc_q;
    mcand_d = start ? {{WIDTH{1'b0}}, mag_a} : busy ? mcand_q << 1 : mcand_q;
    mplier_d = start ? mag_b : busy ? mplier_q >> 1 : mplier_q;
    sign_d = start ? sign : sign_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt_q <= '0;
      acc_q <= '0;
      mcand_q <= '0;
      mplier_q <= '0;
      sign_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      acc_q <= acc_d;
      mcand_q <= mcand_d;
      mplier_q <= mplier_d;
      sign_q <= sign_d;
    end
endmodule

// File: rtl/pipelined_alu.sv
// pipelined_alu: registered EX-stage ALU with valid/ready, overflow, tag passthrough and iterative MUL
// PIPELINED_ALU_SATURATE_EN clamps ADD/SUB results on overflow instead of wrapping
module pipelined_alu import alu_pkg::*; #(parameter int WIDTH = 16, parameter int TAG_W = 4) (
  input logic clk,
  input logic rst,
  input logic flush,
  pipelined_alu_if.slave bus
);
  localparam int M = WIDTH - 1;
  localparam int W2 = 2 * WIDTH;
  state_t state_q, state_d;
  logic out_valid_q, out_valid_d, overflow_q, overflow_d;
  logic [W2-1:0] result_q, result_d, alu_res, product;
  logic [TAG_W-1:0] out_tag_q, out_tag_d, mul_tag_q, mul_tag_d;
  logic [WIDTH-1:0] a, b, sum, dif, lo, mag_a, mag_b;
  logic [2:0] op;
  logic accept, is_mul, start, mul_done, load_alu, load_mul;
  logic add_ovf, sub_ovf, alu_ovf, mul_ovf;
  assign a = bus.op1;
  assign b = bus.op2;
  assign op = bus.alu_ctrl;
  always_comb begin
    sum = a + b;
    dif = a - b;
    add_ovf = (a[M] == b[M]) && (sum[M] != a[M]);
    sub_ovf = (a[M] != b[M]) && (dif[M] != a[M]);
    alu_ovf = op == OP_ADD ? add_ovf : op == OP_SUB ? sub_ovf : 1'b0;
    lo = op == OP_ADD ? sum : op == OP_SUB ? dif : op == OP_MOVE ? b : op == OP_AND ? a & b : a | b;
`ifdef PIPELINED_ALU_SATURATE_EN
    if (alu_ovf) lo = a[M] ? {1'b1, {M{1'b0}}} : {1'b0, {M{1'b1}}};
`endif
    alu_res = op == OP_SWAP ? {a, b} : {{WIDTH{lo[M]}}, lo};
    mag_a = a[M] ? -a : a;
    mag_b = b[M] ? -b : b;
    mul_ovf = !((&product[W2-1:M]) || !(|product[W2-1:M]));
  end
  seq_multiplier #(.WIDTH(WIDTH)) u_mul (
    .clk(clk), .rst(rst), .flush(flush), .start(start),
    .mag_a(mag_a), .mag_b(mag_b), .sign(a[M] ^ b[M]),
    .done(mul_done), .product(product)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) state_q <= ST_IDLE;
    else state_q <= state_d;
  always_comb
    state_d = flush ? ST_IDLE : state_q == ST_IDLE ? (start ? ST_MUL_RUN : ST_IDLE) : (mul_done ? ST_IDLE : ST_MUL_RUN);
  always_comb begin
    bus.in_ready = state_q == ST_IDLE && (!out_valid_q || bus.out_ready) && !flush;
    accept = bus.in_valid && bus.in_ready;
    is_mul = op == OP_MUL;
    start = accept && is_mul;
    load_alu = accept && !is_mul;
    load_mul = state_q == ST_MUL_RUN && mul_done && !flush;
  end
  always_comb begin
    out_valid_d = flush ? 1'b0 : (load_alu || load_mul) ? 1'b1 : out_valid_q && !bus.out_ready;
    result_d = load_alu ? alu_res : load_mul ? product : result_q;
    overflow_d = load_alu ? alu_ovf : load_mul ? mul_ovf : overflow_q;
    out_tag_d = load_alu ? bus.in_tag : load_mul ? mul_tag_q : out_tag_q;
    mul_tag_d = start ? bus.in_tag : mul_tag_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      out_valid_q <= 1'b0;
      result_q <= '0;
      overflow_q <= 1'b0;
      out_tag_q <= '0;
      mul_tag_q <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      result_q <= result_d;
      overflow_q <= overflow_d;
      out_tag_q <= out_tag_d;
      mul_tag_q <= mul_tag_d;
    end
  assign bus.out_valid = out_valid_q;
  assign bus.result = result_q;
  assign bus.overflow = overflow_q;
  assign bus.out_tag = out_tag_q;
endmodule
